// File: rtl/instr_exec_seq.sv
// Execution sequencer: walks a wrapping range of instruction-register locations and
// executes each word. Define INSTR_EXEC_DIV_EN to build the iterative DIV/MOD unit.
module instr_exec_seq #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32,
    parameter int RES_W  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [5:0]            count,
    output logic [ADDR_W-1:0]     read_pointer,
    input  logic [2*OP_W+2:0]     instruction_word,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [RES_W-1:0]      res_data,
    output logic [ADDR_W-1:0]     res_addr,
    output logic [2:0]            res_opc,
    output logic                  res_err,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_DIV    = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    localparam logic [2:0] OPC_ZERO  = 3'd0;
    localparam logic [2:0] OPC_PASSA = 3'd1;
    localparam logic [2:0] OPC_PASSB = 3'd2;
    localparam logic [2:0] OPC_ADD   = 3'd3;
    localparam logic [2:0] OPC_SUB   = 3'd4;
    localparam logic [2:0] OPC_MULT  = 3'd5;
    localparam logic [2:0] OPC_DIV   = 3'd6;
    localparam logic [2:0] OPC_MOD   = 3'd7;
    localparam logic [5:0] MAX_CNT   = 6'd32;

    function automatic logic [RES_W-1:0] sext(input logic [OP_W-1:0] v);
        return {{(RES_W-OP_W){v[OP_W-1]}}, v};
    endfunction

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   rd_ptr_r, rd_ptr_s;
    logic [5:0]          remaining_r, remaining_s;
    logic [2:0]          opc_r, opc_s;
    logic [OP_W-1:0]     a_r, a_s, b_r, b_s;
    logic                res_valid_r, res_valid_s;
    logic [RES_W-1:0]    res_data_r, res_data_s;
    logic [ADDR_W-1:0]   res_addr_r, res_addr_s;
    logic [2:0]          res_opc_r, res_opc_s;
    logic                res_err_r, res_err_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;

    logic [2:0]          dec_opc_s;
    logic [OP_W-1:0]     dec_a_s, dec_b_s;
    logic [RES_W-1:0]    a_ext_s, b_ext_s;
    logic [RES_W-1:0]    exec_data_s;
    logic                exec_err_s;

    assign dec_opc_s = instruction_word[2*OP_W+2 -: 3];
    assign dec_a_s   = instruction_word[2*OP_W-1 -: OP_W];
    assign dec_b_s   = instruction_word[OP_W-1:0];
    assign a_ext_s   = sext(a_r);
    assign b_ext_s   = sext(b_r);

`ifdef INSTR_EXEC_DIV_EN
    localparam int CNT_W = $clog2(OP_W);

    function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] v);
        return v[OP_W-1] ? ((~v) + OP_W'(1)) : v;
    endfunction

    function automatic logic [RES_W-1:0] sneg(input logic [RES_W-1:0] v, input logic neg);
        return neg ? ((~v) + RES_W'(1)) : v;
    endfunction

    logic [OP_W-1:0]     div_quo_r, div_quo_s;
    logic [OP_W-1:0]     div_rem_r, div_rem_s;
    logic [OP_W-1:0]     div_den_r, div_den_s;
    logic [CNT_W-1:0]    div_cnt_r, div_cnt_s;
    logic [OP_W:0]       rem_shift_s;
    logic                trial_ok_s;
    logic [OP_W-1:0]     rem_sub_s;
    logic [RES_W-1:0]    q_ext_s, r_ext_s;

    // Remainder is always below the divisor, so the trial subtraction fits in OP_W bits.
    assign rem_shift_s = {div_rem_r, div_quo_r[OP_W-1]};
    assign trial_ok_s  = (rem_shift_s >= {1'b0, div_den_r});
    assign rem_sub_s   = rem_shift_s[OP_W-1:0] - div_den_r;
    assign q_ext_s     = {{(RES_W-OP_W){1'b0}}, div_quo_r};
    assign r_ext_s     = {{(RES_W-OP_W){1'b0}}, div_rem_r};
`endif

    // Result computation for the EXEC state.
    always_comb begin
        exec_data_s = '0;
        exec_err_s  = 1'b0;
        case (opc_r)
            OPC_ZERO:  exec_data_s = '0;
            OPC_PASSA: exec_data_s = a_ext_s;
            OPC_PASSB: exec_data_s = b_ext_s;
            OPC_ADD:   exec_data_s = a_ext_s + b_ext_s;
            OPC_SUB:   exec_data_s = a_ext_s - b_ext_s;
            OPC_MULT:  exec_data_s = a_ext_s * b_ext_s;
            OPC_DIV, OPC_MOD: begin
`ifdef INSTR_EXEC_DIV_EN
                if (b_r == '0) begin
                    exec_data_s = '0;
                    exec_err_s  = 1'b1;
                end else if (opc_r == OPC_DIV) begin
                    exec_data_s = sneg(q_ext_s, a_r[OP_W-1] ^ b_r[OP_W-1]);
                end else begin
                    exec_data_s = sneg(r_ext_s, a_r[OP_W-1]);
                end
`else
                exec_data_s = '0;
                exec_err_s  = 1'b1;
`endif
            end
            default: begin
                exec_data_s = '0;
                exec_err_s  = 1'b0;
            end
        endcase
    end

    // Next-state and next-register logic for the sequencer.
    always_comb begin
        state_s     = state_r;
        rd_ptr_s    = rd_ptr_r;
        remaining_s = remaining_r;
        opc_s       = opc_r;
        a_s         = a_r;
        b_s         = b_r;
        res_valid_s = res_valid_r;
        res_data_s  = res_data_r;
        res_addr_s  = res_addr_r;
        res_opc_s   = res_opc_r;
        res_err_s   = res_err_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
`ifdef INSTR_EXEC_DIV_EN
        div_quo_s   = div_quo_r;
        div_rem_s   = div_rem_r;
        div_den_s   = div_den_r;
        div_cnt_s   = div_cnt_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (count == 6'd0) begin
                        done_s = 1'b1;
                    end else begin
                        state_s     = S_FETCH;
                        rd_ptr_s    = start_addr;
                        remaining_s = (count > MAX_CNT) ? MAX_CNT : count;
                        busy_s      = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: state_s = S_DECODE;
            S_DECODE: begin
                opc_s = dec_opc_s;
                a_s   = dec_a_s;
                b_s   = dec_b_s;
`ifdef INSTR_EXEC_DIV_EN
                if (((dec_opc_s == OPC_DIV) || (dec_opc_s == OPC_MOD)) && (dec_b_s != '0)) begin
                    state_s   = S_DIV;
                    div_quo_s = mag(dec_a_s);
                    div_rem_s = '0;
                    div_den_s = mag(dec_b_s);
                    div_cnt_s = '0;
                end else begin
                    state_s = S_EXEC;
                end
`else
                state_s = S_EXEC;
`endif
            end
            S_DIV: begin
`ifdef INSTR_EXEC_DIV_EN
                div_rem_s = trial_ok_s ? rem_sub_s : rem_shift_s[OP_W-1:0];
                div_quo_s = {div_quo_r[OP_W-2:0], trial_ok_s};
                div_cnt_s = div_cnt_r + CNT_W'(1);
                if (div_cnt_r == CNT_W'(OP_W-1)) begin
                    state_s = S_EXEC;
                end else begin
                    state_s = S_DIV;
                end
`else
                state_s = S_IDLE;
`endif
            end
            S_EXEC: begin
                res_data_s  = exec_data_s;
                res_err_s   = exec_err_s;
                res_addr_s  = rd_ptr_r;
                res_opc_s   = opc_r;
                res_valid_s = 1'b1;
                state_s     = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_s = 1'b0;
                    remaining_s = remaining_r - 6'd1;
                    if (remaining_r != 6'd1) begin
                        rd_ptr_s = rd_ptr_r + ADDR_W'(1);
                        state_s  = S_FETCH;
                    end else begin
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_OUT;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r    <= '0;
            remaining_r <= 6'd0;
            opc_r       <= 3'd0;
            a_r         <= '0;
            b_r         <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_addr_r  <= '0;
            res_opc_r   <= 3'd0;
            res_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            rd_ptr_r    <= rd_ptr_s;
            remaining_r <= remaining_s;
            opc_r       <= opc_s;
            a_r         <= a_s;
            b_r         <= b_s;
            res_valid_r <= res_valid_s;
            res_data_r  <= res_data_s;
            res_addr_r  <= res_addr_s;
            res_opc_r   <= res_opc_s;
            res_err_r   <= res_err_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

`ifdef INSTR_EXEC_DIV_EN
    // Divider working registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_quo_r <= '0;
            div_rem_r <= '0;
            div_den_r <= '0;
            div_cnt_r <= '0;
        end else begin
            div_quo_r <= div_quo_s;
            div_rem_r <= div_rem_s;
            div_den_r <= div_den_s;
            div_cnt_r <= div_cnt_s;
        end
    end
`endif

    assign read_pointer = rd_ptr_r;
    assign res_valid    = res_valid_r;
    assign res_data     = res_data_r;
    assign res_addr     = res_addr_r;
    assign res_opc      = res_opc_r;
    assign res_err      = res_err_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule
